// File: rtl/alu_pkg.sv
// Shared encodings for the execute stage: ALU op codes, MIPS funct/opcode
// constants and the mul/div FSM states.
package alu_pkg;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_NOR  = 5'd5;
    localparam logic [4:0] ALU_SLT  = 5'd6;
    localparam logic [4:0] ALU_SLTU = 5'd7;
    localparam logic [4:0] ALU_SLL  = 5'd8;
    localparam logic [4:0] ALU_SRL  = 5'd9;
    localparam logic [4:0] ALU_SRA  = 5'd10;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    function automatic logic is_md_funct(input logic [5:0] f);
        return f inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                         F_MULT, F_MULTU, F_DIV, F_DIVU};
    endfunction

endpackage

// File: rtl/md_unit.sv
// Iterative 32-cycle multiply / restoring divide with the HI/LO registers.
// op[1] selects divide, op[0] selects unsigned (funct[1:0] of MULT..DIVU).
//
// state   | meaning
// MD_IDLE | waiting; accepts start and MTHI/MTLO writes
// MD_BUSY | one shift-add or restoring-subtract step per cycle
module md_unit #(
    parameter int MD_ITER = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi_we,
    input  logic        mtlo_we,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    import alu_pkg::*;

    localparam int CW = $clog2(MD_ITER);
    localparam logic [CW-1:0] LAST = CW'(MD_ITER - 1);

    md_state_e     state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opb_q, opb_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic          is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;

    logic          sgn, div_ge;
    logic [31:0]   a_mag, b_mag, step_hi, step_lo;
    logic [32:0]   mul_sum, div_sh, div_diff;
    logic [63:0]   prod;

    always_comb begin
        sgn      = ~op[0];
        a_mag    = (sgn && a[31]) ? (32'd0 - a) : a;
        b_mag    = (sgn && b[31]) ? (32'd0 - b) : b;

        mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : 33'd0);
        div_sh   = {acc_hi_q, acc_lo_q[31]};
        div_diff = div_sh - {1'b0, opb_q};
        div_ge   = div_sh >= {1'b0, opb_q};

        if (is_div_q) begin
            step_hi = div_ge ? div_diff[31:0] : div_sh[31:0];
            step_lo = {acc_lo_q[30:0], div_ge};
        end else begin
            step_hi = mul_sum[32:1];
            step_lo = {mul_sum[0], acc_lo_q[31:1]};
        end
        prod = neg_q ? (64'd0 - {step_hi, step_lo}) : {step_hi, step_lo};

        state_d  = state_q;
        count_d  = count_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            MD_IDLE: begin
                if (mthi_we) hi_d = a;
                if (mtlo_we) lo_d = a;
                if (start) begin
                    acc_hi_d = 32'd0;
                    acc_lo_d = a_mag;
                    opb_d    = b_mag;
                    is_div_d = op[1];
                    neg_d    = sgn & (a[31] ^ b[31]);
                    rneg_d   = sgn & op[1] & a[31];
                    dz_d     = op[1] & (b == 32'd0);
                    count_d  = '0;
                    state_d  = MD_BUSY;
                end
            end
            MD_BUSY: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                count_d  = count_q + 1'b1;
                if (count_q == LAST) begin
                    state_d = MD_IDLE;
                    if (is_div_q) begin
                        // divisor 0 leaves |dividend| as remainder; only LO needs forcing
                        hi_d = rneg_q ? (32'd0 - step_hi) : step_hi;
                        lo_d = dz_q ? 32'hFFFF_FFFF
                                    : (neg_q ? (32'd0 - step_lo) : step_lo);
                    end else begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MD_IDLE;
            count_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opb_q    <= opb_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = (state_q != MD_IDLE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: forwarding muxes, single-cycle ALU, write-register
// select, and the mul/div stall request.
module ex_stage #(
    parameter int XLEN    = 32,
    parameter int MD_ITER = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      ALUControlE,
    input  logic            ALUSrcAE,
    input  logic [1:0]      ALUSrcBE,
    input  logic            RegDstE,
    input  logic [4:0]      rsE,
    input  logic [4:0]      rtE,
    input  logic [4:0]      rdE,
    input  logic [XLEN-1:0] signimmE,
    input  logic [XLEN-1:0] signimmcE,
    input  logic [4:0]      shamtE,
    input  logic [XLEN-1:0] r1_doutE,
    input  logic [XLEN-1:0] r2_doutE,
    input  logic [5:0]      opE,
    input  logic [5:0]      functE,
    input  logic [XLEN-1:0] pcplusE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ALUOutM,
    input  logic [XLEN-1:0] ResultW,
    output logic [XLEN-1:0] ALUOutE,
    output logic [XLEN-1:0] WriteDataE,
    output logic [4:0]      WriteRegE,
    output logic            md_stall,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);
    import alu_pkg::*;

    logic [XLEN-1:0] fwd_a, fwd_b, src_a, src_b, alu_res, hi, lo;
    logic            rtype, is_jal, md_class, md_start, mthi_we, mtlo_we, md_busy;
    logic            unused_rs;

    // rs only matters to the hazard unit
    assign unused_rs = ^rsE;

    always_comb begin
        case (ForwardAE)
            2'b01:   fwd_a = ResultW;
            2'b10:   fwd_a = ALUOutM;
            default: fwd_a = r1_doutE;
        endcase
        case (ForwardBE)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = ALUOutM;
            default: fwd_b = r2_doutE;
        endcase

        src_a = ALUSrcAE ? {{(XLEN-5){1'b0}}, shamtE} : fwd_a;
        case (ALUSrcBE)
            2'b00:   src_b = fwd_b;
            2'b01:   src_b = signimmE;
            2'b10:   src_b = signimmcE;
            default: src_b = {signimmE[15:0], 16'b0};
        endcase

        case (ALUControlE)
            ALU_ADD:  alu_res = src_a + src_b;
            ALU_SUB:  alu_res = src_a - src_b;
            ALU_AND:  alu_res = src_a & src_b;
            ALU_OR:   alu_res = src_a | src_b;
            ALU_XOR:  alu_res = src_a ^ src_b;
            ALU_NOR:  alu_res = ~(src_a | src_b);
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
            ALU_SLL:  alu_res = src_b << src_a[4:0];
            ALU_SRL:  alu_res = src_b >> src_a[4:0];
            ALU_SRA:  alu_res = $signed(src_b) >>> src_a[4:0];
            default:  alu_res = '0;
        endcase

        rtype    = (opE == OP_RTYPE);
        is_jal   = (opE == OP_JAL);
        md_class = rtype & is_md_funct(functE);
        md_start = rtype & (functE inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
        mthi_we  = rtype & (functE == F_MTHI);
        mtlo_we  = rtype & (functE == F_MTLO);

        if (is_jal)                             ALUOutE = pcplusE + 32'd4;
        else if (rtype && functE == F_MFHI)     ALUOutE = hi;
        else if (rtype && functE == F_MFLO)     ALUOutE = lo;
        else                                    ALUOutE = alu_res;

        WriteRegE = is_jal ? 5'd31 : (RegDstE ? rdE : rtE);
    end

    md_unit #(.MD_ITER(MD_ITER)) u_md (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (md_start),
        .op      (functE[1:0]),
        .a       (fwd_a),
        .b       (fwd_b),
        .mthi_we (mthi_we),
        .mtlo_we (mtlo_we),
        .busy    (md_busy),
        .hi      (hi),
        .lo      (lo)
    );

    assign WriteDataE = fwd_b;
    assign md_stall   = md_class & md_busy;
    assign hi_o       = hi;
    assign lo_o       = lo;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: expectations queued at stimulus time,
// popped and compared on the falling edge.
module tb_ex_stage;
    import alu_pkg::*;

    logic        clk, rst_n;
    logic [4:0]  ALUControlE, rsE, rtE, rdE, shamtE, WriteRegE;
    logic        ALUSrcAE, RegDstE, md_stall;
    logic [1:0]  ALUSrcBE, ForwardAE, ForwardBE;
    logic [31:0] signimmE, signimmcE, r1_doutE, r2_doutE, pcplusE, ALUOutM, ResultW;
    logic [5:0]  opE, functE;
    logic [31:0] ALUOutE, WriteDataE, hi_o, lo_o;

    ex_stage #(.XLEN(32), .MD_ITER(32)) dut (
        .clk(clk), .rst_n(rst_n), .ALUControlE(ALUControlE), .ALUSrcAE(ALUSrcAE),
        .ALUSrcBE(ALUSrcBE), .RegDstE(RegDstE), .rsE(rsE), .rtE(rtE), .rdE(rdE),
        .signimmE(signimmE), .signimmcE(signimmcE), .shamtE(shamtE),
        .r1_doutE(r1_doutE), .r2_doutE(r2_doutE), .opE(opE), .functE(functE),
        .pcplusE(pcplusE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ALUOutM(ALUOutM), .ResultW(ResultW), .ALUOutE(ALUOutE),
        .WriteDataE(WriteDataE), .WriteRegE(WriteRegE), .md_stall(md_stall),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    localparam int S_OUT = 0, S_WREG = 1, S_STALL = 2, S_HI = 3, S_LO = 4, S_WDATA = 5;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_OUT:   return ALUOutE;
            S_WREG:  return {27'b0, WriteRegE};
            S_STALL: return {31'b0, md_stall};
            S_HI:    return hi_o;
            S_LO:    return lo_o;
            default: return WriteDataE;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.sel = sel; e.val = v;
        sbq.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk(e.tag, observe(e.sel), e.val);
        end
    endtask

    task automatic clear_in();
        ALUControlE = '0; ALUSrcAE = 0; ALUSrcBE = '0; RegDstE = 0;
        rsE = '0; rtE = '0; rdE = '0; shamtE = '0;
        signimmE = '0; signimmcE = '0; r1_doutE = '0; r2_doutE = '0;
        opE = '0; functE = '0; pcplusE = '0; ForwardAE = '0; ForwardBE = '0;
        ALUOutM = '0; ResultW = '0;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle_check();
        @(negedge clk);
        drain();
    endtask

    function automatic logic [31:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a & b;
            5'd3:  return a | b;
            5'd4:  return a ^ b;
            5'd5:  return ~(a | b);
            5'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd7:  return (a < b) ? 32'd1 : 32'd0;
            5'd8:  return b << a[4:0];
            5'd9:  return b >> a[4:0];
            5'd10: return $signed(b) >>> a[4:0];
            default: return 32'd0;
        endcase
    endfunction

    task automatic md_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] h, output logic [31:0] l);
        logic [63:0] p;
        longint      sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h = '0; l = '0;
        case (f)
            F_MULT:  begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
            F_MULTU: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
            F_DIV: begin
                if (b == 0) begin l = 32'hFFFF_FFFF; h = a; end
                else begin l = 32'(sa / sb); h = 32'(sa % sb); end
            end
            default: begin
                if (b == 0) begin l = 32'hFFFF_FFFF; h = a; end
                else begin l = a / b; h = a % b; end
            end
        endcase
    endtask

    // Start a mul/div, run 'pre' unrelated ADDs, then hold 'follow' (MFHI/MFLO)
    // in EX until the stall drops.
    task automatic run_md(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] hi_e,
                          input logic [31:0] lo_e, input logic [5:0] follow, input int pre);
        int n;
        bit done;
        clear_in();
        functE = f; r1_doutE = a; r2_doutE = b;
        push({tag, "_hi"}, S_HI, hi_e);
        push({tag, "_lo"}, S_LO, lo_e);
        push({tag, "_out"}, S_OUT, (follow == F_MFHI) ? hi_e : lo_e);
        @(negedge clk);
        chk({tag, "_nostall_at_start"}, {31'b0, md_stall}, 32'd0);
        next_cyc();
        for (int i = 0; i < pre; i++) begin
            clear_in();
            ALUControlE = ALU_ADD; r1_doutE = 32'(i + 1); r2_doutE = 32'd10;
            @(negedge clk);
            chk({tag, "_busy_add_stall"}, {31'b0, md_stall}, 32'd0);
            chk({tag, "_busy_add_out"}, ALUOutE, 32'(i + 11));
            next_cyc();
        end
        clear_in();
        functE = follow;
        n = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            if (!md_stall || n >= 100) done = 1;
            else begin
                n++;
                @(posedge clk);
                #1;
            end
        end
        chk({tag, "_stall_len"}, 32'(n), 32'(32 - pre));
        drain();
        next_cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] h, l, a, b;
        logic [5:0]  f;
        logic [5:0]  md_ops [4];
        md_ops[0] = F_MULT; md_ops[1] = F_MULTU; md_ops[2] = F_DIV; md_ops[3] = F_DIVU;

        clear_in();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        push("rst_stall", S_STALL, 0);
        push("rst_hi", S_HI, 0);
        push("rst_lo", S_LO, 0);
        drain();
        rst_n = 1'b1;
        next_cyc();

        ALUControlE = ALU_ADD; ForwardAE = 2'b10; ALUOutM = 32'd5; r2_doutE = 32'd7;
        push("add_fwdA", S_OUT, 12); push("wdata_rf", S_WDATA, 7);
        settle_check(); next_cyc();
        ForwardBE = 2'b01; ResultW = 32'd3;
        push("add_fwdB", S_OUT, 8); push("wdata_w", S_WDATA, 3);
        settle_check(); next_cyc();
        ForwardAE = 2'b11; ForwardBE = 2'b11; r1_doutE = 32'd100;
        push("add_fwd11", S_OUT, 107);
        settle_check(); next_cyc();

        clear_in();
        ALUControlE = ALU_SRA; ALUSrcAE = 1; shamtE = 5'd4; r2_doutE = 32'h8000_0000;
        push("sra_shamt", S_OUT, 32'hF800_0000);
        settle_check(); next_cyc();
        clear_in();
        ALUControlE = ALU_ADD; ALUSrcBE = 2'b11; signimmE = 32'h0000_1234;
        push("lui", S_OUT, 32'h1234_0000);
        settle_check(); next_cyc();
        r1_doutE = 32'd1; ALUSrcBE = 2'b01; signimmE = 32'hFFFF_FFFF;
        push("srcb_simm", S_OUT, 0);
        settle_check(); next_cyc();
        ALUSrcBE = 2'b10; signimmcE = 32'h0000_FFFF;
        push("srcb_zimm", S_OUT, 32'h0001_0000);
        settle_check(); next_cyc();

        for (int i = 0; i < 26; i++) begin
            clear_in();
            ALUControlE = 5'(i % 13);
            r1_doutE = $urandom; r2_doutE = $urandom;
            if (i == 6)  begin r1_doutE = 32'h8000_0000; r2_doutE = 32'd1; end
            if (i == 7)  begin r1_doutE = 32'h8000_0000; r2_doutE = 32'd1; end
            if (i == 14) begin r1_doutE = 32'hFFFF_FFFF; r2_doutE = 32'd1; end
            push($sformatf("alu_op%0d", i % 13), S_OUT,
                 alu_model(ALUControlE, r1_doutE, r2_doutE));
            settle_check(); next_cyc();
        end

        clear_in();
        opE = OP_JAL; pcplusE = 32'h0040_0004; RegDstE = 1; rdE = 5'd9; rtE = 5'd5;
        push("jal_out", S_OUT, 32'h0040_0008); push("jal_wreg", S_WREG, 31);
        settle_check(); next_cyc();
        opE = OP_RTYPE; functE = 6'h20;
        push("wreg_rd", S_WREG, 9);
        settle_check(); next_cyc();
        RegDstE = 0;
        push("wreg_rt", S_WREG, 5);
        settle_check(); next_cyc();

        clear_in();
        functE = F_MTHI; r1_doutE = 32'hA5A5_0001;
        next_cyc();
        functE = F_MTLO; r1_doutE = 32'h5A5A_0002;
        push("mthi_hi", S_HI, 32'hA5A5_0001);
        settle_check(); next_cyc();
        functE = F_MFLO;
        push("mtlo_lo", S_LO, 32'h5A5A_0002); push("mflo_out", S_OUT, 32'h5A5A_0002);
        push("mflo_nostall", S_STALL, 0);
        settle_check(); next_cyc();

        run_md("mult",  F_MULT,  32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, F_MFLO, 0);
        run_md("div",   F_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, F_MFHI, 0);
        run_md("divu0", F_DIVU,  32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, F_MFLO, 3);
        run_md("multu", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, F_MFHI, 5);
        run_md("div_nb", F_DIV,  32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, F_MFLO, 0);
        run_md("div0_s", F_DIV,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, F_MFHI, 0);
        run_md("divu",  F_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, F_MFLO, 1);
        for (int i = 0; i < 4; i++) begin
            f = md_ops[i];
            a = $urandom; b = $urandom;
            if (i >= 2) b = b >> $urandom_range(0, 28);
            if (f == F_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            md_model(f, a, b, h, l);
            run_md($sformatf("rnd%0d", i), f, a, b, h, l, (i % 2 == 0) ? F_MFHI : F_MFLO, i);
        end

        clear_in();
        functE = F_MTHI; r1_doutE = 32'h55;
        next_cyc();
        functE = F_MTLO; r1_doutE = 32'h66;
        next_cyc();
        functE = F_MULTU; r1_doutE = 32'd1234; r2_doutE = 32'd5678;
        next_cyc();
        functE = F_MFHI;
        repeat (10) next_cyc();
        #2;
        chk("pre_rst_stall", {31'b0, md_stall}, 32'd1);
        chk("pre_rst_hi", hi_o, 32'h55);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_stall", {31'b0, md_stall}, 32'd0);
        chk("rst_mid_hi", hi_o, 32'd0);
        chk("rst_mid_lo", lo_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cyc();
        push("post_rst_mfhi", S_OUT, 0); push("post_rst_stall", S_STALL, 0);
        settle_check();
        repeat (40) next_cyc();
        push("post_rst_hi", S_HI, 0); push("post_rst_lo", S_LO, 0);
        settle_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
